instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Writable counterpart of the pipeline's read-only instruction memory.
- Accepts a program as a byte stream over a valid/ready handshake.
- Packs the bytes big-endian into a byte-addressed store of LINE words.
- Serves the fetch stage through the same combinational 32-bit read port.
- Stalls the CPU while a clear or load is in progress, and reports completion or error.

Parameters:
word, 32, instruction width in bits
byte, 8, storage element width in bits
line, 42, capacity in words (store is 4*line bytes)
len_w, 16, width of the load_len word-count port

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load_start  input  1  request to begin a load; sampled only in IDLE
load_len  input  len_w  number of words to load; sampled with load_start
byte_valid  input  1  byte_data is valid
byte_data  input  byte  next program byte; the first byte of each word is its MSB
byte_ready  output  1  loader accepts a byte this cycle
cpu_stall  output  1  holds the pipeline while clearing or loading
load_done  output  1  one-cycle pulse when a load completes
load_err  output  1  sticky flag: rejected load request
read_addr  input  word  byte address from the fetch stage
instruction  output  word  {mem[a], mem[a+1], mem[a+2], mem[a+3]}

Interface decision: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; byte_ready=0, cpu_stall=0, load_done=0, load_err=0.
  - Word and byte counters are zeroed.
  - Memory contents are retained; they are zero at simulation start.
- FSM states: IDLE, CLEAR, LOAD, DONE.
- IDLE, on load_start=1:
  - load_len > line: load_err<=1, stay in IDLE, no memory change.
  - otherwise: latch load_len, clear load_err, go to CLEAR.
  - load_start in any other state is ignored.
- CLEAR:
  - Writes one zero word (4 bytes) per cycle at word index clr_ptr, covering indices 0..line-1.
  - Takes exactly line cycles, then goes to LOAD if the latched len > 0, else to DONE.
- LOAD:
  - byte_ready=1. A byte transfers only on a cycle where byte_valid && byte_ready.
  - Byte k (0-based across the stream) is written to mem[k] on that edge.
  - After byte 4*len-1 transfers, go to DONE. byte_ready drops in the cycle after the final transfer.
  - Gaps with byte_valid=0 are allowed and have no time limit.
- DONE: load_done=1 for exactly one cycle, then IDLE.
- cpu_stall = 1 in CLEAR, LOAD and DONE; 0 in IDLE.
- Read port:
  - Purely combinational and byte-granular; unaligned addresses are legal.
  - instruction = 0 while cpu_stall=1.
  - instruction = 0 when read_addr+3 >= 4*line.
- Reset mid-operation: abort immediately to IDLE with no load_done. Bytes already written remain. Remaining bytes of a partial word are whatever CLEAR left (zero).
- load_err clears only on reset or on the next accepted load_start.
- Counter widths: the byte pointer needs clog2(4*line) bits. Compare against 4*len computed at len_w+2 bits, so there is no overflow.

Decomposition:
- Shared pipeline package holds:
  - word/byte/line constants, shared with the existing instruction memory.
  - The FSM state encoding (IDLE=0, CLEAR=1, LOAD=2, DONE=3).
  - A NOP constant (32'h0).
- One natural sub-module: instr_byte_ram.
  - 4*line x byte storage.
  - Synchronous byte-write port plus a synchronous 4-byte word-clear port.
  - Combinational big-endian 4-byte read with an out-of-range zero.
- The FSM, counters and handshake stay in instr_mem_loader.

Test Plan:
1. Basic load:
   - Stimulus: after reset, load_start with load_len=2; after CLEAR (42 cycles), stream 20 08 00 20 20 09 00 37 back-to-back.
   - Required: load_done pulses one cycle after the last transfer; cpu_stall drops with it; read_addr=0 gives 32'h20080020; read_addr=4 gives 32'h20090037; read_addr=8 gives 0.
2. Backpressure/gaps:
   - Stimulus: same load with byte_valid toggled 1,0,0,1,...
   - Required: identical memory contents; no byte is double-written; byte_ready is never high outside LOAD.
3. Rejected length:
   - Stimulus: load_len=43.
   - Required: load_err=1 the next cycle; cpu_stall never rises; memory is unchanged.
   - Then load_len=1 is accepted and load_err clears.
4. Zero length:
   - Stimulus: load_len=0.
   - Required: a full 42-cycle CLEAR, then load_done; every address reads 0.
5. Reset mid-load:
   - Stimulus: assert reset after 5 bytes of a 3-word load.
   - Required: next cycle IDLE with stall=0 and no load_done; word 0 holds its bytes; word 1 = {b4,00,00,00}.
6. Read boundaries:
   - read_addr=164 gives word 41.
   - read_addr=165 gives 0.
   - read_addr=2 gives {mem2..mem5}.
   - Any address gives 0 while cpu_stall=1.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared constants and FSM encoding for the instruction memory loader
//
// Purpose: word/byte/line sizing shared with the existing instruction memory,
//          the loader FSM state encoding, and the NOP returned by a blocked read.
// Ports:   none (package).

package instr_mem_loader_pkg;

   localparam int WORD      = 32;
   localparam int BYTE      = 8;
   localparam int LINE      = 42;
   localparam int LEN_W     = 16;
   localparam int MEM_BYTES = 4 * LINE;
   localparam int PTR_W     = $clog2(MEM_BYTES);
   localparam int WIDX_W    = $clog2(LINE);

   localparam logic [WORD-1:0] NOP = 32'h0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Byte count of a load, two bits wider than the word count so 4*len never wraps.
   function automatic logic [LEN_W+1:0] len_to_bytes(input logic [LEN_W-1:0] len);
      return {len, 2'b00};
   endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - load stream, status and fetch read port bundle
//
// Purpose: groups the loader's byte-stream handshake, control/status and the
//          fetch-stage read port.
// Signals: load_start/load_len (request), byte_valid/byte_data/byte_ready
//          (byte stream), cpu_stall/load_done/load_err (status),
//          read_addr/instruction (fetch read port).
// Modports: master drives requests/stream/address; slave is the loader.

interface instr_mem_loader_if;
   import instr_mem_loader_pkg::*;

   logic             load_start;
   logic [LEN_W-1:0] load_len;
   logic             byte_valid;
   logic [BYTE-1:0]  byte_data;
   logic             byte_ready;
   logic             cpu_stall;
   logic             load_done;
   logic             load_err;
   logic [WORD-1:0]  read_addr;
   logic [WORD-1:0]  instruction;

   modport master (
      output load_start, load_len, byte_valid, byte_data, read_addr,
      input  byte_ready, cpu_stall, load_done, load_err, instruction
   );

   modport slave (
      input  load_start, load_len, byte_valid, byte_data, read_addr,
      output byte_ready, cpu_stall, load_done, load_err, instruction
   );

endinterface

// File: rtl/instr_byte_ram.sv
// rtl/instr_byte_ram.sv - byte-addressed program store with word clear and big-endian read
//
// Purpose: 4*LINE bytes of storage. One synchronous byte write port, one
//          synchronous 4-byte (word) clear port, and a combinational
//          big-endian 32-bit read at any byte address.
// Ports:   clk_i      rising-edge clock
//          we_i       write wdata_i to byte waddr_i
//          waddr_i    byte write address
//          wdata_i    byte write data
//          clr_i      zero the four bytes of word clr_idx_i (wins over we_i)
//          clr_idx_i  word index to clear
//          raddr_i    byte read address, unaligned allowed
//          rdata_o    {m[a],m[a+1],m[a+2],m[a+3]}, zero when a+3 is past the end

module instr_byte_ram
   import instr_mem_loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [PTR_W-1:0]  waddr_i,
   input  logic [BYTE-1:0]   wdata_i,
   input  logic              clr_i,
   input  logic [WIDX_W-1:0] clr_idx_i,
   input  logic [WORD-1:0]   raddr_i,
   output logic [WORD-1:0]   rdata_o
);

   logic [BYTE-1:0]  mem_q [MEM_BYTES];
   logic [PTR_W-1:0] clr_base;
   logic [WORD:0]    rlast;
   logic             in_range;
   logic [PTR_W-1:0] rbase;

   assign clr_base = PTR_W'({clr_idx_i, 2'b00});

   // No reset: program contents survive a reset of the loader.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int k = 0; k < 4; k++) begin
            mem_q[clr_base + PTR_W'(k)] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // One extra bit so addresses near 2^32 cannot wrap back into range.
   assign rlast    = {1'b0, raddr_i} + (WORD+1)'(3);
   assign in_range = rlast < (WORD+1)'(MEM_BYTES);
   assign rbase    = raddr_i[PTR_W-1:0];

   always_comb begin
      rdata_o = NOP;
      if (in_range) begin
         rdata_o = {mem_q[rbase],
                    mem_q[rbase + PTR_W'(1)],
                    mem_q[rbase + PTR_W'(2)],
                    mem_q[rbase + PTR_W'(3)]};
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - writable instruction memory loaded from a byte stream
//
// Purpose: on load_start (in IDLE) clears the whole store one word per cycle,
//          then accepts 4*load_len bytes over a valid/ready handshake, packing
//          them big-endian, and pulses load_done. Lengths above LINE are
//          rejected with a sticky load_err. The pipeline is stalled and the
//          read port returns NOP while any of this is in progress.
// Ports:   clk    rising-edge clock
//          reset  synchronous active-high reset
//          bus    instr_mem_loader_if.slave (stream, status, fetch read port)

module instr_mem_loader
   import instr_mem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   instr_mem_loader_if.slave  bus
);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [WIDX_W-1:0]   clr_ptr_q, clr_ptr_d;
   logic [PTR_W-1:0]    byte_ptr_q, byte_ptr_d;
   logic                load_err_q, load_err_d;

   logic                ram_we;
   logic                ram_clr;
   logic [WORD-1:0]     ram_rdata;
   logic                xfer;
   logic                last_byte;

   assign xfer      = (state_q == ST_LOAD) && bus.byte_valid;
   assign last_byte = ((LEN_W+2)'(byte_ptr_q) + (LEN_W+2)'(1)) == len_to_bytes(len_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         clr_ptr_q  <= '0;
         byte_ptr_q <= '0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         clr_ptr_q  <= clr_ptr_d;
         byte_ptr_q <= byte_ptr_d;
         load_err_q <= load_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      clr_ptr_d  = clr_ptr_q;
      byte_ptr_d = byte_ptr_q;
      load_err_d = load_err_q;
      ram_we     = 1'b0;
      ram_clr    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.load_start) begin
               if (bus.load_len > LEN_W'(LINE)) begin
                  load_err_d = 1'b1;
               end else begin
                  len_d      = bus.load_len;
                  load_err_d = 1'b0;
                  clr_ptr_d  = '0;
                  state_d    = ST_CLEAR;
               end
            end
         end
         ST_CLEAR: begin
            ram_clr = 1'b1;
            if (clr_ptr_q == WIDX_W'(LINE - 1)) begin
               clr_ptr_d  = '0;
               byte_ptr_d = '0;
               state_d    = (len_q != '0) ? ST_LOAD : ST_DONE;
            end else begin
               clr_ptr_d = clr_ptr_q + WIDX_W'(1);
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               ram_we     = 1'b1;
               byte_ptr_d = byte_ptr_q + PTR_W'(1);
               if (last_byte) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   instr_byte_ram u_ram (
      .clk_i     (clk),
      .we_i      (ram_we),
      .waddr_i   (byte_ptr_q),
      .wdata_i   (bus.byte_data),
      .clr_i     (ram_clr),
      .clr_idx_i (clr_ptr_q),
      .raddr_i   (bus.read_addr),
      .rdata_o   (ram_rdata)
   );

   assign bus.byte_ready  = (state_q == ST_LOAD);
   assign bus.cpu_stall   = (state_q != ST_IDLE);
   assign bus.load_done   = (state_q == ST_DONE);
   assign bus.load_err    = load_err_q;
   assign bus.instruction = bus.cpu_stall ? NOP : ram_rdata;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader

module tb_instr_mem_loader;

   localparam int N_WORDS = 42;
   localparam int N_BYTES = 4 * N_WORDS;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_mem_loader_if bus();

   instr_mem_loader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference image of the program store.
   logic [7:0] mm [N_BYTES];

   function automatic logic [31:0] model_read(input logic [31:0] a, input bit stall);
      longint last;
      last = longint'(a) + 3;
      if (stall || last >= N_BYTES) return 32'h0;
      return {mm[a], mm[a+1], mm[a+2], mm[a+3]};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N_BYTES; i++) mm[i] = 8'h00;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int len);
      bus.load_len   = 16'(len);
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
   endtask

   // Runs through CLEAR, probing the read port (must be NOP); returns cycles spent.
   task automatic wait_clear(output int n);
      logic [31:0] a;
      n = 0;
      while (!bus.byte_ready && !bus.load_done && n < 200) begin
         a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, N_BYTES + 3));
         bus.read_addr = a;
         #1;
         total_cnt++;
         if (bus.instruction !== model_read(a, 1'b1))
            $display("FAIL stall_read addr=%0d got %h want %h", a, bus.instruction, model_read(a, 1'b1));
         else pass_cnt++;
         tick();
         n++;
      end
      model_clear();
   endtask

   // mode 0: back-to-back, 1: valid pattern 1,0,0,1,..., 2: random gaps
   task automatic stream(input logic [7:0] bytes[$], input int mode);
      int idx = 0;
      int cyc = 0;
      bit v;
      while (idx < bytes.size() && cyc < 4000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 3 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         if (v) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = bytes[idx];
            total_cnt++;
            if (bus.byte_ready !== 1'b1)
               $display("FAIL ready_in_load byte=%0d got %b want 1", idx, bus.byte_ready);
            else pass_cnt++;
            mm[idx] = bytes[idx];
            idx++;
         end else begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
         end
         tick();
         cyc++;
      end
      bus.byte_valid = 1'b0;
      total_cnt++;
      if (idx != bytes.size())
         $display("FAIL stream_timeout got %0d bytes want %0d", idx, bytes.size());
      else pass_cnt++;
   endtask

   task automatic expect_done();
      total_cnt++;
      if ({bus.load_done, bus.byte_ready, bus.cpu_stall} !== 3'b101)
         $display("FAIL done_pulse got done/ready/stall=%b%b%b want 101",
                  bus.load_done, bus.byte_ready, bus.cpu_stall);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({bus.load_done, bus.cpu_stall, bus.byte_ready} !== 3'b000)
         $display("FAIL done_end got done/stall/ready=%b%b%b want 000",
                  bus.load_done, bus.cpu_stall, bus.byte_ready);
      else pass_cnt++;
   endtask

   task automatic check_clear_len(input int n);
      total_cnt++;
      if (n != N_WORDS) $display("FAIL clear_cycles got %0d want %0d", n, N_WORDS);
      else pass_cnt++;
   endtask

   task automatic check_mem(input string tag);
      logic [31:0] a;
      for (int i = 0; i < N_BYTES + 6; i++) begin
         a = 32'(i);
         bus.read_addr = a;
         #1;
         total_cnt++;
         if (bus.instruction !== model_read(a, 1'b0))
            $display("FAIL %s addr=%0d got %h want %h", tag, a, bus.instruction, model_read(a, 1'b0));
         else pass_cnt++;
      end
      a = 32'hFFFF_FFFE;
      bus.read_addr = a;
      #1;
      total_cnt++;
      if (bus.instruction !== 32'h0)
         $display("FAIL %s_wrap addr=%h got %h want 0", tag, a, bus.instruction);
      else pass_cnt++;
   endtask

   task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] want);
      bus.read_addr = a;
      #1;
      total_cnt++;
      if (bus.instruction !== want)
         $display("FAIL %s addr=%0d got %h want %h", tag, a, bus.instruction, want);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.load_start = 1'b0;
      bus.load_len   = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      bus.read_addr  = '0;
      tick();
      tick();
      total_cnt++;
      if ({bus.byte_ready, bus.cpu_stall, bus.load_done, bus.load_err} !== 4'b0000)
         $display("FAIL reset_state got ready/stall/done/err=%b%b%b%b want 0000",
                  bus.byte_ready, bus.cpu_stall, bus.load_done, bus.load_err);
      else pass_cnt++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_load();
      logic [7:0] q[$] = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
      int n;
      start_load(2);
      wait_clear(n);
      check_clear_len(n);
      stream(q, 0);
      expect_done();
      read_expect("basic_w0", 32'd0, 32'h2008_0020);
      read_expect("basic_w1", 32'd4, 32'h2009_0037);
      read_expect("basic_w2", 32'd8, 32'h0);
      check_mem("basic_mem");
   endtask

   task automatic test_gaps();
      logic [7:0] q[$] = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
      logic [7:0] r[$];
      int n;
      int len;
      start_load(2);
      wait_clear(n);
      check_clear_len(n);
      stream(q, 1);
      expect_done();
      read_expect("gap_w0", 32'd0, 32'h2008_0020);
      read_expect("gap_w1", 32'd4, 32'h2009_0037);
      check_mem("gap_mem");
      len = $urandom_range(1, 6);
      for (int i = 0; i < 4 * len; i++) r.push_back(8'($urandom));
      start_load(len);
      wait_clear(n);
      check_clear_len(n);
      stream(r, 2);
      expect_done();
      check_mem("rand_gap_mem");
   endtask

   task automatic test_reject();
      logic [7:0] q[$];
      int n;
      int bad[2] = '{43, 65535};
      foreach (bad[b]) begin
         start_load(bad[b]);
         total_cnt++;
         if (bus.load_err !== 1'b1) $display("FAIL reject_err len=%0d got %b want 1", bad[b], bus.load_err);
         else pass_cnt++;
         for (int c = 0; c < 4; c++) begin
            total_cnt++;
            if (bus.cpu_stall !== 1'b0 || bus.byte_ready !== 1'b0)
               $display("FAIL reject_stall got stall=%b ready=%b want 0 0", bus.cpu_stall, bus.byte_ready);
            else pass_cnt++;
            tick();
         end
         total_cnt++;
         if (bus.load_err !== 1'b1) $display("FAIL reject_sticky got %b want 1", bus.load_err);
         else pass_cnt++;
      end
      check_mem("reject_mem");
      start_load(1);
      total_cnt++;
      if (bus.load_err !== 1'b0) $display("FAIL accept_clears_err got %b want 0", bus.load_err);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      wait_clear(n);
      check_clear_len(n);
      stream(q, 2);
      expect_done();
      check_mem("accept_mem");
   endtask

   task automatic test_zero_len();
      int n;
      start_load(0);
      wait_clear(n);
      check_clear_len(n);
      total_cnt++;
      if (bus.load_done !== 1'b1) $display("FAIL zero_done got %b want 1", bus.load_done);
      else pass_cnt++;
      expect_done();
      check_mem("zero_mem");
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] q[$];
      int n;
      for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
      start_load(3);
      wait_clear(n);
      check_clear_len(n);
      stream(q, 0);
      reset = 1'b1;
      tick();
      total_cnt++;
      if ({bus.cpu_stall, bus.load_done, bus.byte_ready} !== 3'b000)
         $display("FAIL midreset_state got stall/done/ready=%b%b%b want 000",
                  bus.cpu_stall, bus.load_done, bus.byte_ready);
      else pass_cnt++;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         total_cnt++;
         if (bus.load_done !== 1'b0) $display("FAIL midreset_no_done got %b want 0", bus.load_done);
         else pass_cnt++;
      end
      read_expect("midreset_w0", 32'd0, {q[0], q[1], q[2], q[3]});
      read_expect("midreset_w1", 32'd4, {q[4], 24'h0});
      check_mem("midreset_mem");
   endtask

   task automatic test_boundaries();
      logic [7:0] q[$];
      logic [7:0] s[$];
      int n;
      for (int i = 0; i < N_BYTES; i++) q.push_back(8'($urandom));
      start_load(N_WORDS);
      wait_clear(n);
      check_clear_len(n);
      stream(q, 2);
      expect_done();
      read_expect("bound_164", 32'd164, {q[164], q[165], q[166], q[167]});
      read_expect("bound_165", 32'd165, 32'h0);
      read_expect("bound_2",   32'd2,   {q[2], q[3], q[4], q[5]});
      check_mem("bound_mem");
      for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
      start_load(1);
      wait_clear(n);
      check_clear_len(n);
      stream(s, 0);
      expect_done();
      check_mem("after_stall_mem");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_load();
      test_gaps();
      test_reject();
      test_zero_len();
      test_reset_mid_load();
      test_boundaries();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
